// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared types for the RGB fade sequencer: FSM state encoding and channel count.
package rgb_fade_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFade  = 2'd1,
        StDwell = 2'd2
    } seq_state_e;

    localparam int unsigned NumChan = 3;

endpackage

// File: rtl/tick_divider.sv
// Prescaler: tick pulses every DIV cycles while run is high; cleared whenever run drops.
module tick_divider #(
    parameter int unsigned DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run || (cnt_q == LastCnt)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = run && (cnt_q == LastCnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Autonomous palette sequencer: fades three PWM levels linearly between palette entries,
// dwells at each colour and wraps around the palette.
module rgb_fade_sequencer
    import rgb_fade_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ENTRIES     = 4,
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned DWELL_TICKS = 64,
    localparam int unsigned IDXW       = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [IDXW-1:0]      load_idx,
    input  logic [3*WIDTH-1:0]   load_rgb,
    output logic [WIDTH-1:0]     level0,
    output logic [WIDTH-1:0]     level1,
    output logic [WIDTH-1:0]     level2,
    output logic                 level_valid,
    output logic                 seg_done,
    output logic [IDXW-1:0]      cur_idx,
    output logic                 busy
);

    localparam int unsigned DWW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DWW-1:0] LastDwell = DWW'(DWELL_TICKS - 1);

    // Channel [2] is red, [0] is blue, so a packed {r,g,b} word maps straight across.
    typedef logic [NumChan-1:0][WIDTH-1:0] rgb_t;

    seq_state_e          state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [DWW-1:0]      dwell_q, dwell_d;
    rgb_t                level_q, level_d;
    rgb_t                target_q, target_d;
    rgb_t                stepped;
    logic                level_valid_q, level_valid_d;
    logic                seg_done_q, seg_done_d;
    logic [3*WIDTH-1:0]  palette_q [ENTRIES];

    logic                tick;
    logic                run;
    logic                write_en;
    logic [IDXW-1:0]     sel_idx;
    logic [3*WIDTH-1:0]  sel_word;

    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] lvl,
                                                     input logic [WIDTH-1:0] tgt);
        if (lvl < tgt) begin
            return lvl + WIDTH'(1);
        end else if (lvl > tgt) begin
            return lvl - WIDTH'(1);
        end
        return lvl;
    endfunction

    assign run      = enable && (state_q != StIdle);
    assign write_en = load_valid && load_ready;

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tick    (tick)
    );

    // Entry about to become the target; a same-cycle write to it wins over the stored value.
    always_comb begin
        sel_idx  = (state_q == StDwell) ? idx_q + 1'b1 : idx_q;
        sel_word = (write_en && (load_idx == sel_idx)) ? load_rgb : palette_q[sel_idx];
    end

    always_comb begin
        stepped = level_q;
        for (int c = 0; c < NumChan; c++) begin
            stepped[c] = step_toward(level_q[c], target_q[c]);
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dwell_d       = dwell_q;
        level_d       = level_q;
        target_d      = target_q;
        level_valid_d = 1'b0;
        seg_done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StFade;
                    target_d = rgb_t'(sel_word);
                end
            end
            StFade: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    level_d       = stepped;
                    level_valid_d = (stepped != level_q);
                    if (stepped == target_q) begin
                        seg_done_d = 1'b1;
                        dwell_d    = '0;
                        state_d    = StDwell;
                    end
                end
            end
            StDwell: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (dwell_q == LastDwell) begin
                        dwell_d  = '0;
                        idx_d    = sel_idx;
                        target_d = rgb_t'(sel_word);
                        state_d  = StFade;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            dwell_q       <= '0;
            level_q       <= '0;
            target_q      <= '0;
            level_valid_q <= 1'b0;
            seg_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dwell_q       <= dwell_d;
            level_q       <= level_d;
            target_q      <= target_d;
            level_valid_q <= level_valid_d;
            seg_done_q    <= seg_done_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                palette_q[i] <= '0;
            end
        end else if (write_en) begin
            palette_q[load_idx] <= load_rgb;
        end
    end

    assign load_ready  = (state_q != StFade);
    assign busy        = (state_q != StIdle);
    assign level0      = level_q[2];
    assign level1      = level_q[1];
    assign level2      = level_q[0];
    assign level_valid = level_valid_q;
    assign seg_done    = seg_done_q;
    assign cur_idx     = idx_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer: directed table, corner sequences and a
// randomized run against a segment-level reference model.
module tb_rgb_fade_sequencer;

    localparam int TDIV  = 4;
    localparam int DWELL = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [1:0]  load_idx = '0;
    logic [23:0] load_rgb = '0;
    logic [7:0]  level0, level1, level2;
    logic        level_valid, seg_done, busy;
    logic [1:0]  cur_idx;

    int total = 0;
    int bad = 0;
    int n = 0;
    int hs_count = 0;

    rgb_fade_sequencer #(
        .WIDTH       (8),
        .ENTRIES     (4),
        .TICK_DIV    (TDIV),
        .DWELL_TICKS (DWELL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_idx    (load_idx),
        .load_rgb    (load_rgb),
        .level0      (level0),
        .level1      (level1),
        .level2      (level2),
        .level_valid (level_valid),
        .seg_done    (seg_done),
        .cur_idx     (cur_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (load_valid && load_ready) hs_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int t);
        while (n < t) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        load_valid = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic load(input int i, input logic [23:0] rgb);
        check("load_ready_idle", load_ready, 1);
        load_valid = 1'b1;
        load_idx = 2'(i);
        load_rgb = rgb;
        step();
        load_valid = 1'b0;
    endtask

    task automatic start();
        enable = 1'b1;
        step();
        n = 0;
    endtask

    task automatic check_rgb(input string name, input int r, input int g, input int b);
        check({name, "_r"}, level0, r);
        check({name, "_g"}, level1, g);
        check({name, "_b"}, level2, b);
    endtask

    // ---------------- reference model (segment arithmetic) ----------------
    int m_ph;   // 0 idle, 1 fading, 2 dwelling
    int m_cyc;  // running cycles since entering the current phase
    int m_idx;
    int m_st[3], m_tg[3], m_lv[3];
    logic [23:0] m_pal[4];
    bit m_valid, m_done;

    function automatic int chan(input logic [23:0] rgb, input int c);
        return int'((rgb >> (16 - 8 * c)) & 24'hFF);
    endfunction

    function automatic int approach(input int s, input int t, input int k);
        int d = t - s;
        if (d > 0) return s + ((k < d) ? k : d);
        if (d < 0) return s - ((k < -d) ? k : -d);
        return s;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cyc = 0; m_idx = 0; m_valid = 0; m_done = 0;
        for (int c = 0; c < 3; c++) begin
            m_st[c] = 0; m_tg[c] = 0; m_lv[c] = 0;
        end
        for (int i = 0; i < 4; i++) m_pal[i] = '0;
    endtask

    task automatic model_target(input int sel, input bit wr, input int li, input logic [23:0] rgb);
        logic [23:0] w;
        w = (wr && li == sel) ? rgb : m_pal[sel];
        for (int c = 0; c < 3; c++) begin
            m_tg[c] = chan(w, c);
            m_st[c] = m_lv[c];
        end
        m_cyc = 0;
        m_ph = 1;
    endtask

    task automatic model_step(input bit en, input bit v, input int li, input logic [23:0] rgb);
        bit wr;
        bit hit;
        int k;
        int nl;
        wr = v && (m_ph != 1);
        m_valid = 0;
        m_done = 0;
        if (m_ph == 0) begin
            if (en) model_target(m_idx, wr, li, rgb);
        end else if (!en) begin
            m_ph = 0;
        end else begin
            m_cyc++;
            if (m_cyc % TDIV == 0) begin
                k = m_cyc / TDIV;
                if (m_ph == 1) begin
                    hit = 1;
                    for (int c = 0; c < 3; c++) begin
                        nl = approach(m_st[c], m_tg[c], k);
                        if (nl != m_lv[c]) m_valid = 1;
                        m_lv[c] = nl;
                        if (nl != m_tg[c]) hit = 0;
                    end
                    if (hit) begin
                        m_done = 1;
                        m_ph = 2;
                        m_cyc = 0;
                    end
                end else if (k == DWELL) begin
                    m_idx = (m_idx + 1) % 4;
                    model_target(m_idx, wr, li, rgb);
                end
            end
        end
        if (wr) m_pal[li] = rgb;
    endtask

    // ---------------- directed table for the basic two-entry fade ----------------
    typedef struct {
        int         at_edge;
        logic [7:0] r, g, b;
        logic [1:0] idx;
        logic       lv;
        logic       seg;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int hs_base;
        bit en;
        bit v;
        int li;
        logic [23:0] rgb;

        vecs[0]  = '{0,   8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1,   8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{4,   8'h01, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{8,   8'h02, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{63,  8'h0F, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{64,  8'h10, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1};
        vecs[6]  = '{72,  8'h10, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0};
        vecs[7]  = '{76,  8'h0F, 8'h00, 8'h01, 2'd1, 1'b1, 1'b0};
        vecs[8]  = '{84,  8'h0D, 8'h00, 8'h03, 2'd1, 1'b1, 1'b0};
        vecs[9]  = '{136, 8'h00, 8'h00, 8'h03, 2'd1, 1'b1, 1'b1};
        vecs[10] = '{144, 8'h00, 8'h00, 8'h03, 2'd2, 1'b0, 1'b0};
        vecs[11] = '{156, 8'h00, 8'h00, 8'h00, 2'd2, 1'b1, 1'b1};

        // Reset state
        step();
        do_reset();
        step();
        check_rgb("rst", 0, 0, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", cur_idx, 0);
        check("rst_ready", load_ready, 1);
        check("rst_lv", level_valid, 0);
        check("rst_seg", seg_done, 0);

        // Basic fade sequence
        load(0, 24'h100000);
        load(1, 24'h000003);
        start();
        for (int i = 0; i < 12; i++) begin
            run_to(vecs[i].at_edge);
            check_rgb($sformatf("tbl%0d", i), vecs[i].r, vecs[i].g, vecs[i].b);
            check($sformatf("tbl%0d_idx", i), cur_idx, vecs[i].idx);
            check($sformatf("tbl%0d_lv", i), level_valid, vecs[i].lv);
            check($sformatf("tbl%0d_seg", i), seg_done, vecs[i].seg);
            check($sformatf("tbl%0d_busy", i), busy, 1);
        end

        // Handshake: writes are refused during FADE, accepted exactly once in DWELL
        do_reset();
        load(0, 24'h020000);
        load(1, 24'h000001);
        start();
        hs_base = hs_count;
        load_valid = 1'b1; load_idx = 2'd1; load_rgb = 24'h000009;
        run_to(1);
        check("hs_ready_fade1", load_ready, 0);
        run_to(2);
        check("hs_ready_fade2", load_ready, 0);
        load_valid = 1'b0;
        run_to(4);
        load_valid = 1'b1; load_rgb = 24'h000004;
        for (int w = 0; w < 20 && !load_ready; w++) begin
            step();
            n++;
        end
        check("hs_ready_edge", n, 8);
        check("hs_ready_dwell", load_ready, 1);
        step();
        n++;
        load_valid = 1'b0;
        check("hs_accept_once", hs_count - hs_base, 1);
        run_to(32);
        check_rgb("hs_new_target", 0, 0, 4);
        check("hs_seg", seg_done, 1);
        check("hs_idx", cur_idx, 1);

        // Bypass: write to the next entry in the very cycle the dwell expires
        do_reset();
        load(0, 24'h010101);
        start();
        run_to(4);
        check_rgb("byp_first", 1, 1, 1);
        check("byp_seg0", seg_done, 1);
        run_to(11);
        load_valid = 1'b1; load_idx = 2'd1; load_rgb = 24'h050505;
        run_to(12);
        load_valid = 1'b0;
        check("byp_idx", cur_idx, 1);
        run_to(16);
        check_rgb("byp_step", 2, 2, 2);
        run_to(22);
        check_rgb("byp_mid", 3, 3, 3);
        // Asynchronous reset mid-fade takes effect before the next edge
        reset_n = 1'b0;
        #1;
        check_rgb("arst", 0, 0, 0);
        check("arst_busy", busy, 0);
        check("arst_idx", cur_idx, 0);
        check("arst_ready", load_ready, 1);
        #1;
        reset_n = 1'b1;

        // Wrap from the last entry back to 0
        do_reset();
        load(3, 24'h010101);
        start();
        run_to(36);
        check("wrap_idx3", cur_idx, 3);
        run_to(40);
        check_rgb("wrap_at3", 1, 1, 1);
        check("wrap_seg3", seg_done, 1);
        run_to(48);
        check("wrap_idx0", cur_idx, 0);
        run_to(52);
        check_rgb("wrap_back", 0, 0, 0);
        check("wrap_seg0", seg_done, 1);

        // Pause and resume
        do_reset();
        load(0, 24'h0A0000);
        start();
        run_to(28);
        check("pause_l0", level0, 8'h07);
        enable = 1'b0;
        run_to(29);
        check("pause_busy", busy, 0);
        run_to(39);
        check("pause_hold", level0, 8'h07);
        check("pause_idx", cur_idx, 0);
        check("pause_lv", level_valid, 0);
        start();
        check("resume_busy", busy, 1);
        run_to(4);
        check("resume_l0", level0, 8'h08);
        run_to(12);
        check("resume_done", level0, 8'h0A);
        check("resume_seg", seg_done, 1);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            en = ($urandom_range(0, 99) < 97);
            v = ($urandom_range(0, 99) < 15);
            li = int'($urandom_range(0, 3));
            rgb = {4'h0, 4'($urandom_range(0, 15)), 4'h0, 4'($urandom_range(0, 15)),
                   4'h0, 4'($urandom_range(0, 15))};
            enable = en;
            load_valid = v;
            load_idx = 2'(li);
            load_rgb = rgb;
            check("rnd_ready", load_ready, (m_ph != 1) ? 1 : 0);
            model_step(en, v, li, rgb);
            step();
            check("rnd_l0", level0, m_lv[0]);
            check("rnd_l1", level1, m_lv[1]);
            check("rnd_l2", level2, m_lv[2]);
            check("rnd_idx", cur_idx, m_idx);
            check("rnd_busy", busy, (m_ph != 0) ? 1 : 0);
            check("rnd_lv", level_valid, m_valid);
            check("rnd_seg", seg_done, m_done);
        end
        load_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
